// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for the timer sequencer.
// Rev 1.0
`default_nettype none

package timer_pkg;

  localparam int DEF_COUNTER_SIZE  = 8;
  localparam int DEF_PRESCALE_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider, tick when count equals div, then wraps to 0.
// Rev 1.0
`default_nettype none

module timer_prescaler #(
  parameter int prescale_size = 8
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [prescale_size-1:0] div,
  output logic                     tick
);

  logic [prescale_size-1:0] count;

  assign tick = (count == div);

  // Returning to 0 on tick keeps count <= div, so it can never overflow its width.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + prescale_size'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// timer_ctrl: sequences an external up/down counter as a prescaled down-counting timer.
// Rev 1.0
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int counter_size  = DEF_COUNTER_SIZE,
  parameter int prescale_size = DEF_PRESCALE_SIZE
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode_periodic,
  input  logic [counter_size-1:0]  reload_val,
  input  logic [prescale_size-1:0] prescale_val,
  input  logic [counter_size-1:0]  cnt_out,
  output logic                     cnt_enable,
  output logic                     cnt_load,
  output logic                     cnt_dir,
  output logic [counter_size-1:0]  cnt_in,
  output logic                     busy,
  output logic                     expired
);

  timer_state_t state, state_nxt;

  logic [counter_size-1:0]  reload_q;
  logic [prescale_size-1:0] prescale_q;
  logic                     mode_q;
  logic                     expired_q;
  logic                     busy_q;

  logic tick;
  logic run_tick;
  logic terminal;
  logic accept;
  logic pre_clear;
  logic pre_enable;

  timer_prescaler #(
    .prescale_size (prescale_size)
  ) u_prescaler (
    .clk    (clk),
    .res_n  (res_n),
    .clear  (pre_clear),
    .enable (pre_enable),
    .div    (prescale_q),
    .tick   (tick)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    run_tick   = (state == RUN) && tick;
    terminal   = run_tick && (cnt_out == '0);
    pre_enable = (state == RUN);
    pre_clear  = stop || (state != RUN);
    cnt_load   = (state == LOAD);
    // Holding enable low on the terminal tick stops the counter wrapping to all-ones.
    cnt_enable = (state == LOAD) || (run_tick && (cnt_out != '0));

    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (terminal) begin
          state_nxt = mode_q ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (stop) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      reload_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      expired_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      expired_q <= terminal && !stop;
      busy_q    <= (state_nxt != IDLE);
      if (accept) begin
        reload_q   <= reload_val;
        prescale_q <= prescale_val;
        mode_q     <= mode_periodic;
      end
    end
  end

  assign cnt_dir = 1'b1;
  assign cnt_in  = reload_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: timer_ctrl driving a behavioural up/down counter, checked against a cycle-offset model.
// Rev 1.0
`default_nettype none

module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       res_n;
  logic       start, stop, mode_periodic;
  logic [7:0] reload_val, prescale_val;
  logic [7:0] cnt_out;
  logic       cnt_enable, cnt_load, cnt_dir, busy, expired;
  logic [7:0] cnt_in;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: one active timing run described by its LOAD cycle and latched config.
  int m_active = 0, m_t0 = 0, m_r = 0, m_p = 0, m_mode = 0, m_exp = 0;
  int load_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  timer_ctrl #(
    .counter_size  (8),
    .prescale_size (8)
  ) dut (
    .clk           (clk),
    .res_n         (res_n),
    .start         (start),
    .stop          (stop),
    .mode_periodic (mode_periodic),
    .reload_val    (reload_val),
    .prescale_val  (prescale_val),
    .cnt_out       (cnt_out),
    .cnt_enable    (cnt_enable),
    .cnt_load      (cnt_load),
    .cnt_dir       (cnt_dir),
    .cnt_in        (cnt_in),
    .busy          (busy),
    .expired       (expired)
  );

  // The attached generic up/down counter, sharing res_n.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_out <= 8'd0;
    end else if (cnt_enable) begin
      if (cnt_load) cnt_out <= cnt_in;
      else if (cnt_dir) cnt_out <= cnt_out - 8'd1;
      else cnt_out <= cnt_out + 8'd1;
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(negedge clk) begin
    int per, off, e_load, e_en, term, done;
    if (!res_n) begin
      m_active = 0; m_r = 0; m_p = 0; m_mode = 0; m_exp = 0;
    end
    per    = m_p + 1;
    off    = cyc - m_t0;
    e_load = (m_active != 0) && (off == 0);
    e_en   = e_load || ((m_active != 0) && off > 0 && (off % per) == 0 && (off / per) <= m_r);
    term   = (m_active != 0) && (off == (m_r + 1) * per);
    chk("cnt_load", cnt_load, e_load);
    chk("cnt_enable", cnt_enable, e_en);
    chk("busy", busy, m_active);
    chk("expired", expired, m_exp);
    chk("cnt_in", cnt_in, m_r);
    chk("cnt_dir", cnt_dir, 1);
    if (m_active != 0 && off > 0) begin
      done = (off - 1) / per;
      if (done > m_r) done = m_r;
      chk("cnt_out", cnt_out, m_r - done);
    end
    if (cnt_load) load_q.push_back(cyc);
    if (expired) exp_q.push_back(cyc);
    if (res_n) begin
      m_exp = 0;
      if (stop) begin
        m_active = 0;
      end else if (m_active == 0) begin
        if (start) begin
          m_active = 1; m_t0 = cyc + 1;
          m_r = reload_val; m_p = prescale_val; m_mode = mode_periodic;
        end
      end else if (term != 0) begin
        m_exp = 1;
        if (m_mode != 0) m_t0 = cyc + 1;
        else m_active = 0;
      end
    end
    cyc++;
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(logic s, logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic cfg(int r, int p, logic m);
    reload_val    = 8'(r);
    prescale_val  = 8'(p);
    mode_periodic = m;
    load_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_exp(int limit);
    int n = 0;
    while (exp_q.size() == 0 && n < limit) begin
      idle(1);
      n++;
    end
    chk("wait_expired", int'(exp_q.size() > 0), 1);
  endtask

  task automatic chk_intervals(string name, int first_gap, int gap, int count);
    chk({name, "_count"}, int'(exp_q.size() >= count), 1);
    if (exp_q.size() > 0 && load_q.size() > 0) chk({name, "_first"}, exp_q[0] - load_q[0], first_gap);
    for (int i = 1; i < count && i < exp_q.size(); i++)
      chk({name, "_gap"}, exp_q[i] - exp_q[i-1], gap);
  endtask

  initial begin
    res_n = 1'b0; start = 1'b0; stop = 1'b0;
    mode_periodic = 1'b0; reload_val = 8'd0; prescale_val = 8'd0;
    idle(3);
    res_n = 1'b1;

    cfg(0, 0, 1'b0);
    idle(20);
    chk("idle_loads", load_q.size(), 0);
    chk("idle_expired", exp_q.size(), 0);

    // One-shot R=3 P=0: LOAD at t+1, expiry at t+6.
    cfg(3, 0, 1'b0);
    pulse(1'b1, 1'b0);
    idle(10);
    chk("os_loads", load_q.size(), 1);
    chk("os_pulses", exp_q.size(), 1);
    if (exp_q.size() > 0 && load_q.size() > 0) chk("os_latency", exp_q[0] - load_q[0], 5);
    chk("os_busy", busy, 0);
    chk("os_cnt_out", cnt_out, 0);

    // Periodic R=2 P=1: period 7, mid-run reload_val change ignored.
    cfg(2, 1, 1'b1);
    pulse(1'b1, 1'b0);
    idle(10);
    reload_val = 8'd9;
    idle(30);
    chk_intervals("per", 7, 7, 5);
    pulse(1'b0, 1'b1);
    chk("per_stop_busy", busy, 0);

    // Prescale max: R=0 P=255, expiry 257 cycles after LOAD.
    cfg(0, 255, 1'b0);
    pulse(1'b1, 1'b0);
    wait_exp(400);
    if (exp_q.size() > 0 && load_q.size() > 0) chk("pmax_latency", exp_q[0] - load_q[0], 257);
    idle(3);

    // Stop in the middle of RUN.
    cfg(5, 2, 1'b0);
    pulse(1'b1, 1'b0);
    idle(6);
    pulse(1'b0, 1'b1);
    chk("stop_run_busy", busy, 0);
    idle(30);
    chk("stop_run_expired", exp_q.size(), 0);

    // Stop exactly in the terminal-tick cycle (LOAD t+1, terminal t+4).
    cfg(2, 0, 1'b1);
    pulse(1'b1, 1'b0);
    idle(3);
    pulse(1'b0, 1'b1);
    chk("stop_term_busy", busy, 0);
    idle(5);
    chk("stop_term_expired", exp_q.size(), 0);
    chk("stop_term_loads", load_q.size(), 1);

    // start and stop together in IDLE.
    cfg(1, 0, 1'b0);
    pulse(1'b1, 1'b1);
    idle(3);
    chk("startstop_loads", load_q.size(), 0);
    chk("startstop_busy", busy, 0);

    // start while busy is ignored: period stays (1+1)(2+1)+1 = 7.
    cfg(1, 2, 1'b1);
    pulse(1'b1, 1'b0);
    idle(10);
    reload_val = 8'd4;
    pulse(1'b1, 1'b0);
    idle(30);
    chk_intervals("busy_start", 7, 7, 5);
    pulse(1'b0, 1'b1);

    // Asynchronous reset mid-RUN.
    cfg(5, 3, 1'b1);
    pulse(1'b1, 1'b0);
    idle(8);
    #2 res_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_enable", cnt_enable, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_cnt_in", cnt_in, 0);
    chk("rst_cnt_out", cnt_out, 0);
    chk("rst_expired", expired, 0);
    idle(2);
    res_n = 1'b1;
    idle(5);
    chk("rst_after_busy", busy, 0);

    // Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 2000; i++) begin
      start         = ($urandom % 6) == 0;
      stop          = ($urandom % 50) == 0;
      mode_periodic = $urandom % 2;
      reload_val    = 8'($urandom % 6);
      prescale_val  = 8'($urandom % 4);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pulse(1'b0, 1'b1);
    idle(3);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
